// File: rtl/match_controller.sv
// match_controller
//   Rally/match sequencer for the Pong ball. It holds the ball at the serve
//   position, releases it after a serve delay, detects misses against the
//   court limits, keeps both scores, steps ball speed up as a rally grows,
//   and declares a winner. Clocked by game_clk, one tick per frame.
//
// Ports
//   game_clk   in   1  game tick clock
//   rst        in   1  synchronous, active-high reset
//   start      in   1  debounced start button (level; rising edge used)
//   ball_x     in  10  current ball x position
//   paddle_hit in   1  one-cycle pulse on a bounce off either paddle
//   ball_hold  out  1  1 = ball kept at serve position (0 only in PLAY)
//   serve_dir  out  1  0 = launch toward player 1 (left), 1 = toward player 2
//   speed      out  2  ball speed step, 0..MAX_SPEED
//   score_p1   out  4  player 1 score
//   score_p2   out  4  player 2 score
//   point      out  1  one-cycle pulse when a point is awarded
//   winner     out  2  00 none, 01 player 1, 10 player 2
//   state      out  3  IDLE=0 SERVE=1 PLAY=2 SCORED=3 OVER=4
module match_controller #(
  parameter int unsigned LEFT_LIMIT   = 8,
  parameter int unsigned RIGHT_LIMIT  = 632,
  parameter int unsigned SERVE_TICKS  = 60,
  parameter int unsigned POINT_TICKS  = 90,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SPEEDUP_HITS = 4,
  parameter int unsigned MAX_SPEED    = 3
) (
  input  logic       game_clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] ball_x,
  input  logic       paddle_hit,
  output logic       ball_hold,
  output logic       serve_dir,
  output logic [1:0] speed,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       point,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_SCORED = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  localparam logic [9:0] LEFT_X     = 10'(LEFT_LIMIT);
  localparam logic [9:0] RIGHT_X    = 10'(RIGHT_LIMIT);
  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_TICKS - 1);
  localparam logic [7:0] POINT_LOAD = 8'(POINT_TICKS - 1);
  localparam logic [3:0] WIN_PTS    = 4'(WIN_SCORE);
  localparam logic [3:0] HIT_WRAP   = 4'(SPEEDUP_HITS - 1);
  localparam logic [1:0] SPEED_MAX  = 2'(MAX_SPEED);

  // State is stored as a raw vector so the unused encodings 5..7 can be
  // held and decoded back to IDLE.
  logic [2:0] r_state;
  logic [7:0] r_timer;
  logic [3:0] r_hit_cnt;
  logic       r_start_d;
  logic       r_ball_hold;
  logic       r_serve_dir;
  logic [1:0] r_speed;
  logic [3:0] r_score_p1;
  logic [3:0] r_score_p2;
  logic       r_point;
  logic [1:0] r_winner;

  state_t     w_state;
  state_t     w_state_nxt;
  logic [7:0] w_timer_nxt;
  logic [3:0] w_hit_cnt_nxt;
  logic       w_serve_dir_nxt;
  logic [1:0] w_speed_nxt;
  logic [3:0] w_score_p1_nxt;
  logic [3:0] w_score_p2_nxt;
  logic       w_point_nxt;
  logic [1:0] w_winner_nxt;
  logic       w_ball_hold_nxt;
  logic       w_start_rise;
  logic       w_miss_l;
  logic       w_miss_r;
  logic       w_won;

  assign w_state      = state_t'(r_state);
  assign w_start_rise = start & ~r_start_d;
  assign w_miss_l     = (ball_x <= LEFT_X);
  assign w_miss_r     = (ball_x >= RIGHT_X);

  always_comb begin
    w_state_nxt     = w_state;
    w_timer_nxt     = r_timer;
    w_hit_cnt_nxt   = r_hit_cnt;
    w_serve_dir_nxt = r_serve_dir;
    w_speed_nxt     = r_speed;
    w_score_p1_nxt  = r_score_p1;
    w_score_p2_nxt  = r_score_p2;
    w_point_nxt     = 1'b0;
    w_winner_nxt    = r_winner;
    w_won           = 1'b0;

    case (w_state)
      ST_IDLE, ST_OVER: begin
        if (w_start_rise) begin
          w_state_nxt    = ST_SERVE;
          w_timer_nxt    = SERVE_LOAD;
          w_score_p1_nxt = '0;
          w_score_p2_nxt = '0;
          w_speed_nxt    = '0;
          w_hit_cnt_nxt  = '0;
          w_winner_nxt   = '0;
        end
      end

      ST_SERVE: begin
        if (r_timer == '0) w_state_nxt = ST_PLAY;
        else               w_timer_nxt = r_timer - 8'd1;
      end

      ST_PLAY: begin
        if (w_miss_l || w_miss_r) begin
          // A miss overrides any paddle hit in the same tick; left first.
          if (w_miss_l) begin
            w_score_p2_nxt  = r_score_p2 + 4'd1;
            w_serve_dir_nxt = 1'b0;
            w_won           = (w_score_p2_nxt == WIN_PTS);
          end else begin
            w_score_p1_nxt  = r_score_p1 + 4'd1;
            w_serve_dir_nxt = 1'b1;
            w_won           = (w_score_p1_nxt == WIN_PTS);
          end
          w_point_nxt   = 1'b1;
          w_speed_nxt   = '0;
          w_hit_cnt_nxt = '0;
          if (w_won) begin
            w_state_nxt  = ST_OVER;
            w_winner_nxt = w_miss_l ? 2'b10 : 2'b01;
          end else begin
            w_state_nxt = ST_SCORED;
            w_timer_nxt = POINT_LOAD;
          end
        end else if (paddle_hit) begin
          if (r_hit_cnt == HIT_WRAP) begin
            w_hit_cnt_nxt = '0;
            if (r_speed < SPEED_MAX) w_speed_nxt = r_speed + 2'd1;
          end else begin
            w_hit_cnt_nxt = r_hit_cnt + 4'd1;
          end
        end
      end

      ST_SCORED: begin
        if (r_timer == '0) begin
          w_state_nxt = ST_SERVE;
          w_timer_nxt = SERVE_LOAD;
        end else begin
          w_timer_nxt = r_timer - 8'd1;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    w_ball_hold_nxt = (w_state_nxt != ST_PLAY);
  end

  always_ff @(posedge game_clk) begin
    // start_d follows start even during reset, so a button held through
    // reset is not mistaken for a fresh press once reset drops.
    r_start_d <= start;
    if (rst) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_hit_cnt   <= '0;
      r_ball_hold <= 1'b1;
      r_serve_dir <= 1'b1;
      r_speed     <= '0;
      r_score_p1  <= '0;
      r_score_p2  <= '0;
      r_point     <= 1'b0;
      r_winner    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_hit_cnt   <= w_hit_cnt_nxt;
      r_ball_hold <= w_ball_hold_nxt;
      r_serve_dir <= w_serve_dir_nxt;
      r_speed     <= w_speed_nxt;
      r_score_p1  <= w_score_p1_nxt;
      r_score_p2  <= w_score_p2_nxt;
      r_point     <= w_point_nxt;
      r_winner    <= w_winner_nxt;
    end
  end

  assign ball_hold = r_ball_hold;
  assign serve_dir = r_serve_dir;
  assign speed     = r_speed;
  assign score_p1  = r_score_p1;
  assign score_p2  = r_score_p2;
  assign point     = r_point;
  assign winner    = r_winner;
  assign state     = r_state;

endmodule
